pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-stage controller that owns the program counter and sequences next-PC selection for instruction fetch. Sits between the next-PC selection logic (sequential +4, jump/branch destination, interrupt vector) and the instruction-memory port. Arbitrates redirect sources, holds the PC across pipeline stalls and memory wait states, and squashes any in-flight fetch that a redirect makes stale. Feeds decode with a fetched-PC/valid pair.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  decode cannot accept; hold current fetched PC
- jmp  in  1  branch/jump redirect request, one-cycle pulse
- dest  in  32  jump/branch target, valid with jmp
- int_flush  in  1  interrupt/exception redirect, one-cycle pulse
- int_pc  in  32  handler address, valid with int_flush
- if_req  out  1  fetch request to instruction memory
- if_addr  out  32  fetch address, stable while if_req=1 and if_ack=0
- if_ack  in  1  memory accepted and returned the word this cycle
- id_valid  out  1  id_pc holds a fetched, non-squashed instruction PC
- id_pc  out  32  PC of the instruction presented to decode
- redirect_pend  out  1  a captured redirect is waiting to be applied
- misalign  out  1  (PC_MISALIGN_EN only) applied target had [1:0]≠0, one-cycle pulse

## Operation
- States: BOOT, REQ, HOLD.
- BOOT: entered on reset; one cycle with if_req=0, then REQ with pc=RESET_PC.
- REQ: if_req=1, if_addr=pc. Without if_ack: stay, pc unchanged.
- REQ with if_ack, no redirect pending or arriving: id_pc<=pc, id_valid<=1; stall=0 → pc<=pc+4, stay REQ; stall=1 → HOLD.
- REQ with if_ack and redirect pending or arriving same cycle: response discarded (id_valid<=0), pc<=target, pending cleared, stay REQ.
- Redirect in REQ without if_ack: captured into pending; outstanding request completes unchanged (handshake not abandoned); applied on its if_ack.
- HOLD: if_req=0, id_valid and id_pc held. stall falls → pc<=pc+4, go REQ, id_valid<=0 unless next ack. Redirect in HOLD overrides stall: id_valid<=0, pc<=target, go REQ next cycle.
- Priority: int_flush over jmp same cycle. Pending jmp overwritten by later int_flush; pending int_flush never overwritten by jmp; later int_flush overwrites earlier int_flush.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000).
- Redirect_pend=1 from the cycle after capture until the cycle after application.

## Timing
- Reset values: if_req=0, if_addr=RESET_PC, id_valid=0, id_pc=0, redirect_pend=0, misalign=0, state=BOOT.
- All outputs registered; no combinational path from inputs to outputs.
- First if_req one cycle after rst deasserts (BOOT).
- Back-to-back fetch: with if_ack every cycle and stall=0, if_addr advances by 4 each cycle.
- Redirect latency: jmp in the same cycle as if_ack → if_addr=dest on the next cycle. Redirect in HOLD → if_addr=target next cycle.
- Reset mid-request: if_req drops immediately (async); request abandoned; restart at RESET_PC.

## Configuration
- PC_MISALIGN_EN defined: applied target with [1:0]≠0 pulses misalign for one cycle, and fetch proceeds at target with [1:0] forced to 0.
- Undefined: no misalign port; target loaded verbatim, low bits unchecked.

## Structure
- Shared package: state encoding (BOOT/REQ/HOLD), RESET_PC default, PC increment constant 4, redirect-source encoding (NONE/JMP/INT).
- One sub-module, redirect_latch: priority capture of int_flush/jmp, holding target and source until the apply strobe.

## Test plan
- Reset release, if_ack tied 1, stall 0 → if_addr 0x0, 0x4, 0x8 on consecutive cycles from the cycle after BOOT.
- if_ack held 0 for 3 cycles at pc 0x10 → if_addr stays 0x10, id_valid unchanged; ack → id_pc=0x10, next if_addr=0x14.
- stall=1 for 4 cycles after ack of 0x20 → id_pc=0x20, id_valid=1 throughout, if_req=0; release → if_addr=0x24.
- jmp dest=0x400 while request at 0x30 is waiting → 0x30 response discarded (id_valid 0), next if_addr=0x400, redirect_pend high in between.
- jmp dest=0x400 and int_flush int_pc=0x8000_0180 in the same cycle → next if_addr=0x8000_0180.
- pc=0xFFFF_FFFC acked, stall 0 → next if_addr=0x0000_0000; with PC_MISALIGN_EN, jmp dest=0x102 → misalign pulse, if_addr=0x100.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and constants for the fetch-stage PC sequencer.
// Optional feature macro: PC_MISALIGN_EN (word-align applied redirect targets).
package pc_sequencer_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Source of a captured redirect; INT outranks JMP
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_INT  = 2'd2
    } redir_src_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // Address actually fetched for a redirect target
    function automatic logic [31:0] align_target(input logic [31:0] target);
`ifdef PC_MISALIGN_EN
        return {target[31:2], 2'b00};
`else
        return target;
`endif
    endfunction

endpackage

// File: rtl/pc_sequencer_redirect_latch.sv
// pc_sequencer_redirect_latch: priority capture of int_flush/jmp redirects.
// Holds target and source until the apply strobe; also presents the
// effective redirect (pending merged with one arriving this cycle).
module pc_sequencer_redirect_latch
    import pc_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        jmp,
    input  logic [31:0] dest,
    input  logic        int_flush,
    input  logic [31:0] int_pc,
    input  logic        apply,
    output logic        pend,
    output logic        redir_valid,
    output logic [31:0] redir_target
);

    redir_src_t  src_reg;
    logic [31:0] target_reg;
    logic        pend_reg;
    redir_src_t  sel_src;
    logic [31:0] sel_target;

    // Merge arriving request with the pending one: int_flush always wins,
    // jmp may only replace an empty or jmp-sourced entry
    always_comb begin
        sel_src    = src_reg;
        sel_target = target_reg;
        if (int_flush) begin
            sel_src    = SRC_INT;
            sel_target = int_pc;
        end else if (jmp && (src_reg != SRC_INT)) begin
            sel_src    = SRC_JMP;
            sel_target = dest;
        end
    end

    assign redir_valid  = (sel_src != SRC_NONE);
    assign redir_target = sel_target;
    assign pend         = pend_reg;

    // Capture the merged redirect until the controller consumes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_reg    <= SRC_NONE;
            target_reg <= '0;
            pend_reg   <= 1'b0;
        end else if (apply) begin
            src_reg    <= SRC_NONE;
            pend_reg   <= 1'b0;
        end else begin
            src_reg    <= sel_src;
            target_reg <= sel_target;
            pend_reg   <= (sel_src != SRC_NONE);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter owner and next-PC sequencer.
// Optional feature macro: PC_MISALIGN_EN adds the misalign output and
// forces applied redirect targets to word alignment.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] dest,
    input  logic        int_flush,
    input  logic [31:0] int_pc,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_ack,
    output logic        id_valid,
    output logic [31:0] id_pc,
`ifdef PC_MISALIGN_EN
    output logic        misalign,
`endif
    output logic        redirect_pend
);

    state_t      state;
    logic [31:0] pc_reg;
    logic        if_req_reg;
    logic        id_valid_reg;
    logic [31:0] id_pc_reg;
    logic        apply;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic [31:0] redir_addr;
    logic [31:0] pc_inc;
`ifdef PC_MISALIGN_EN
    logic        misalign_reg;
`endif

    pc_sequencer_redirect_latch u_redirect_latch (
        .clk          (clk),
        .rst          (rst),
        .jmp          (jmp),
        .dest         (dest),
        .int_flush    (int_flush),
        .int_pc       (int_pc),
        .apply        (apply),
        .pend         (redirect_pend),
        .redir_valid  (redir_valid),
        .redir_target (redir_target)
    );

    // A redirect is consumed either on the ack of the outstanding request or
    // immediately while holding (no request is outstanding then)
    assign apply      = redir_valid && (((state == REQ) && if_ack) || (state == HOLD));
    assign redir_addr = align_target(redir_target);
    assign pc_inc     = pc_reg + PC_INC;

    // Fetch FSM; the PC register doubles as the registered fetch address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            pc_reg       <= RESET_PC;
            if_req_reg   <= 1'b0;
            id_valid_reg <= 1'b0;
            id_pc_reg    <= '0;
`ifdef PC_MISALIGN_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
`ifdef PC_MISALIGN_EN
            misalign_reg <= 1'b0;
`endif
            case (state)
                BOOT: begin
                    state      <= REQ;
                    pc_reg     <= RESET_PC;
                    if_req_reg <= 1'b1;
                end
                REQ: begin
                    if (if_ack) begin
                        if (redir_valid) begin
                            // Returned word is stale: drop it and restart at target
                            id_valid_reg <= 1'b0;
                            pc_reg       <= redir_addr;
`ifdef PC_MISALIGN_EN
                            misalign_reg <= |redir_target[1:0];
`endif
                        end else begin
                            id_pc_reg    <= pc_reg;
                            id_valid_reg <= 1'b1;
                            if (stall) begin
                                state      <= HOLD;
                                if_req_reg <= 1'b0;
                            end else begin
                                pc_reg     <= pc_inc;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (redir_valid) begin
                        id_valid_reg <= 1'b0;
                        pc_reg       <= redir_addr;
                        state        <= REQ;
                        if_req_reg   <= 1'b1;
`ifdef PC_MISALIGN_EN
                        misalign_reg <= |redir_target[1:0];
`endif
                    end else if (!stall) begin
                        id_valid_reg <= 1'b0;
                        pc_reg       <= pc_inc;
                        state        <= REQ;
                        if_req_reg   <= 1'b1;
                    end
                end
                default: begin
                    state      <= BOOT;
                    if_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign if_req   = if_req_reg;
    assign if_addr  = pc_reg;
    assign id_valid = id_valid_reg;
    assign id_pc    = id_pc_reg;
`ifdef PC_MISALIGN_EN
    assign misalign = misalign_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer.
// Honours PC_MISALIGN_EN when the design is built with it.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jmp;
    logic [31:0] dest;
    logic        int_flush;
    logic [31:0] int_pc;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        redirect_pend;
`ifdef PC_MISALIGN_EN
    logic        misalign;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .jmp           (jmp),
        .dest          (dest),
        .int_flush     (int_flush),
        .int_pc        (int_pc),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_ack        (if_ack),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
`ifdef PC_MISALIGN_EN
        .misalign      (misalign),
`endif
        .redirect_pend (redirect_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; jmp = 1'b0; dest = '0;
        int_flush = 1'b0; int_pc = '0; if_ack = 1'b0;

        #3;
        check_val("rst_if_req",   32'(if_req), 32'h0);
        check_val("rst_if_addr",  if_addr, 32'h0);
        check_val("rst_id_valid", 32'(id_valid), 32'h0);
        check_val("rst_id_pc",    id_pc, 32'h0);
        check_val("rst_pend",     32'(redirect_pend), 32'h0);
`ifdef PC_MISALIGN_EN
        check_val("rst_misalign", 32'(misalign), 32'h0);
`endif

        @(negedge clk);
        rst = 1'b0;
        cyc();                                          // BOOT -> REQ
        check_val("boot_if_req",  32'(if_req), 32'h1);
        check_val("boot_if_addr", if_addr, 32'h0);
        check_val("boot_id_valid", 32'(id_valid), 32'h0);

        // Back-to-back fetch
        if_ack = 1'b1;
        cyc();
        check_val("seq_addr_4", if_addr, 32'h4);
        check_val("seq_id_pc_0", id_pc, 32'h0);
        check_val("seq_id_valid", 32'(id_valid), 32'h1);
        cyc();
        check_val("seq_addr_8", if_addr, 32'h8);
        cyc();
        check_val("seq_addr_c", if_addr, 32'hC);
        cyc();
        check_val("seq_addr_10", if_addr, 32'h10);
        check_val("seq_id_pc_c", id_pc, 32'hC);

        // Memory wait states at 0x10
        if_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("wait_addr", if_addr, 32'h10);
            check_val("wait_id_valid", 32'(id_valid), 32'h1);
            check_val("wait_id_pc", id_pc, 32'hC);
        end
        if_ack = 1'b1;
        cyc();
        check_val("wait_ack_id_pc", id_pc, 32'h10);
        check_val("wait_ack_addr", if_addr, 32'h14);
        cyc(); cyc(); cyc();
        check_val("pre_stall_addr", if_addr, 32'h20);

        // Stall after ack of 0x20
        stall = 1'b1;
        cyc();
        check_val("stall_if_req", 32'(if_req), 32'h0);
        check_val("stall_id_pc", id_pc, 32'h20);
        check_val("stall_id_valid", 32'(id_valid), 32'h1);
        if_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("hold_if_req", 32'(if_req), 32'h0);
            check_val("hold_id_valid", 32'(id_valid), 32'h1);
            check_val("hold_id_pc", id_pc, 32'h20);
        end
        stall = 1'b0;
        cyc();
        check_val("release_if_req", 32'(if_req), 32'h1);
        check_val("release_addr", if_addr, 32'h24);
        check_val("release_id_valid", 32'(id_valid), 32'h0);

        if_ack = 1'b1;
        cyc();
        check_val("after_rel_id_pc", id_pc, 32'h24);
        cyc(); cyc();
        check_val("pre_jmp_addr", if_addr, 32'h30);

        // jmp while request at 0x30 waits
        if_ack = 1'b0; jmp = 1'b1; dest = 32'h400;
        cyc();
        jmp = 1'b0;
        check_val("jwait_addr", if_addr, 32'h30);
        check_val("jwait_pend", 32'(redirect_pend), 32'h1);
        check_val("jwait_if_req", 32'(if_req), 32'h1);
        cyc();
        check_val("jwait2_pend", 32'(redirect_pend), 32'h1);
        check_val("jwait2_addr", if_addr, 32'h30);
        if_ack = 1'b1;
        cyc();
        check_val("japply_addr", if_addr, 32'h400);
        check_val("japply_id_valid", 32'(id_valid), 32'h0);
        check_val("japply_pend", 32'(redirect_pend), 32'h0);

        // jmp and int_flush together with ack: interrupt wins
        jmp = 1'b1; dest = 32'h400; int_flush = 1'b1; int_pc = 32'h8000_0180;
        cyc();
        jmp = 1'b0; int_flush = 1'b0;
        check_val("prio_addr", if_addr, 32'h8000_0180);
        check_val("prio_id_valid", 32'(id_valid), 32'h0);
        check_val("prio_pend", 32'(redirect_pend), 32'h0);

        // Pending int_flush is not replaced by a later jmp
        if_ack = 1'b0; int_flush = 1'b1; int_pc = 32'h200;
        cyc();
        int_flush = 1'b0;
        check_val("pint_pend", 32'(redirect_pend), 32'h1);
        check_val("pint_addr", if_addr, 32'h8000_0180);
        jmp = 1'b1; dest = 32'h300;
        cyc();
        jmp = 1'b0;
        if_ack = 1'b1;
        cyc();
        check_val("pint_apply_addr", if_addr, 32'h200);

        // Redirect while holding overrides the stall
        stall = 1'b1;
        cyc();
        check_val("hred_if_req", 32'(if_req), 32'h0);
        check_val("hred_id_pc", id_pc, 32'h200);
        if_ack = 1'b0; jmp = 1'b1; dest = 32'h500;
        cyc();
        jmp = 1'b0; stall = 1'b0;
        check_val("hred_req", 32'(if_req), 32'h1);
        check_val("hred_addr", if_addr, 32'h500);
        check_val("hred_id_valid", 32'(id_valid), 32'h0);

        // PC wrap at the top of the address space
        if_ack = 1'b1; jmp = 1'b1; dest = 32'hFFFF_FFFC;
        cyc();
        jmp = 1'b0;
        check_val("wrap_top_addr", if_addr, 32'hFFFF_FFFC);
        cyc();
        check_val("wrap_addr", if_addr, 32'h0);
        check_val("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

`ifdef PC_MISALIGN_EN
        jmp = 1'b1; dest = 32'h102;
        cyc();
        jmp = 1'b0;
        check_val("mis_addr", if_addr, 32'h100);
        check_val("mis_pulse", 32'(misalign), 32'h1);
        cyc();
        check_val("mis_clear", 32'(misalign), 32'h0);
        check_val("mis_next_addr", if_addr, 32'h104);
`endif

        // Asynchronous reset in the middle of a request
        if_ack = 1'b0;
        cyc();
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_if_req", 32'(if_req), 32'h0);
        check_val("arst_if_addr", if_addr, 32'h0);
        check_val("arst_id_valid", 32'(id_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        check_val("arst_restart_req", 32'(if_req), 32'h1);
        check_val("arst_restart_addr", if_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
